comp_serial_nbit: RTL and testbench
===================================

# comp_serial_nbit

Parametrised sequential magnitude comparator, the next generation of the team's combinational n-bit comparator. It latches two N-bit operands on a start strobe and compares them bit-serially, MSB first, one bit per clock. It terminates early on the first differing bit and reports registered gt/eq/lt with a one-cycle done pulse. It serves area-constrained datapaths where an N-wide parallel comparator is too costly and multi-cycle latency is acceptable.

## Interface
Parameters:
- N, 8, operand width in bits (N >= 2)

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  request; accepted only in IDLE
- A  input  N  operand A, sampled on accepted start
- B  input  N  operand B, sampled on accepted start
- sgn  input  1  two's-complement mode, sampled on accepted start (present only with COMP_SIGNED_EN)
- busy  output  1  high while state != IDLE
- done  output  1  one-cycle pulse, results valid
- gt  output  1  A > B
- eq  output  1  A == B
- lt  output  1  A < B

## Operation
- Registers: shift regs sa, sb (N bits each), down-counter cnt ($clog2(N) bits), mode flag, state, result flags gt/eq/lt.
- FSM states: IDLE, CMP, DONE.
- IDLE: on start=1, load sa<=A, sb<=B, cnt<=N-1, latch mode, clear gt/eq/lt to 0, go to CMP. With start=0, stay in IDLE.
- CMP: each cycle, compare sa[N-1] and sb[N-1].
  - If the bits differ: a=1,b=0 sets gt; a=0,b=1 sets lt; go to DONE.
  - If equal and cnt==0: set eq; go to DONE.
  - Otherwise shift sa and sb left by 1, decrement cnt.
- Signed mode affects only the first compared bit (the sign bit): the result is inverted there (a=1,b=0 gives lt). All later bits compare unsigned.
- DONE: done=1 for exactly this cycle; go to IDLE next edge.
- Results: exactly one of gt/eq/lt is 1 after a decision. They hold until the next accepted start or reset.
- start while busy (CMP or DONE): ignored, no queuing. A and B changes while busy have no effect.

## Timing
- Reset (asynchronous, any state): state=IDLE, busy=0, done=0, gt=eq=lt=0, sa=sb=0, cnt=0. An operation in flight is abandoned.
- Accept edge E0: start=1 in IDLE; busy=1 from E0.
- Decision edge E0+k:
  - k = N−i, where i is the index of the highest differing bit.
  - k = N if A==B.
- Result flags update and done=1 during the cycle following E0+k.
- busy falls at E0+k+1.
- Latency: 1 cycle best case (MSB differs), N cycles worst case (equal, or only bit 0 differs).
- Minimum start-to-start spacing: k+2 cycles.
- start asserted in the same cycle busy falls is accepted.

## Configuration
- COMP_SIGNED_EN defined:
  - sgn port exists.
  - sgn=1 selects two's-complement comparison.
  - sgn=0 selects unsigned comparison.
- COMP_SIGNED_EN undefined:
  - sgn port and mode register are absent.
  - All comparisons are unsigned.
  - Timing is unchanged.

## Structure
- Package comp_pkg holds:
  - state encoding constants: IDLE=2'd0, CMP=2'd1, DONE=2'd2
  - helper for counter width CNT_W = $clog2(N)
- Sub-module comp_bit_cell: combinational one-bit compare.
  - Inputs: a, b, invert.
  - Outputs: a_gt, a_lt.
  - Instantiated once on the MSBs of the shift registers.
- The top holds the FSM, counter, shift registers and result flags.

## Test plan
All cases use N=4.
- Assert rst mid-cycle, asynchronously → all outputs 0 immediately; state IDLE.
- A=9, B=3, start → done one cycle after the decision at E0+1; gt=1, eq=0, lt=0; busy low after done.
- A=5, B=5 → decision at E0+4; eq=1. Then A=4, B=5 → decision at E0+4; lt=1.
- Signed build: A=4'b1000, B=4'b0111, sgn=1 → lt=1 at E0+1. Same operands with sgn=0 → gt=1.
- start pulsed every cycle with changing A/B during CMP → ignored; result reflects the first operands; back-to-back start on the cycle busy falls → accepted.
- rst asserted at E0+2 of an equal-operand compare → no done pulse; outputs 0; next start with A=2, B=1 → gt=1 at E0+3.

Source files
------------

// File: rtl/comp_pkg.sv
// Shared constants for the bit-serial magnitude comparator: FSM state encoding
// and the down-counter width helper.
package comp_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CMP  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // Counter width for an N-bit serial compare. It is never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/comp_bit_cell.sv
// One-bit magnitude compare cell. With invert set it ranks the bit as a
// two's-complement sign bit: a 1 is the smaller value.
module comp_bit_cell (
   input  logic a,
   input  logic b,
   input  logic invert,
   output logic a_gt,
   output logic a_lt
);

   logic raw_gt;
   logic raw_lt;

   assign raw_gt = a & ~b;
   assign raw_lt = ~a & b;
   assign a_gt   = invert ? raw_lt : raw_gt;
   assign a_lt   = invert ? raw_gt : raw_lt;

endmodule

// File: rtl/comp_serial_nbit.sv
// Bit-serial N-bit magnitude comparator. It compares MSB first and exits early
// on the first differing bit. Defining COMP_SIGNED_EN adds the sgn input, which
// selects two's-complement mode.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; results from the last compare are held
// CMP   | comparing the MSBs of sa/sb, one bit per clock
// DONE  | one-cycle done pulse; results are valid
module comp_serial_nbit
   import comp_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
`ifdef COMP_SIGNED_EN
   input  logic         sgn,
`endif
   output logic         busy,
   output logic         done,
   output logic         gt,
   output logic         eq,
   output logic         lt
);

   localparam int CNT_W = cnt_w(N);
   localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(N - 1);

   logic [1:0]       state;
   logic [N-1:0]     sa;
   logic [N-1:0]     sb;
   logic [CNT_W-1:0] cnt;
   logic             invert;
   logic             bit_gt;
   logic             bit_lt;

`ifdef COMP_SIGNED_EN
   logic mode;

   // Only the first compared bit is the sign bit. The counter is still at its top value on that bit.
   assign invert = mode & (cnt == CNT_TOP);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         mode <= 1'b0;
      else if (state == IDLE && start)
         mode <= sgn;
   end
`else
   assign invert = 1'b0;
`endif

   comp_bit_cell u_msb (
      .a      (sa[N-1]),
      .b      (sb[N-1]),
      .invert (invert),
      .a_gt   (bit_gt),
      .a_lt   (bit_lt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         sa    <= '0;
         sb    <= '0;
         cnt   <= '0;
         gt    <= 1'b0;
         eq    <= 1'b0;
         lt    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  sa    <= A;
                  sb    <= B;
                  cnt   <= CNT_TOP;
                  gt    <= 1'b0;
                  eq    <= 1'b0;
                  lt    <= 1'b0;
                  state <= CMP;
               end
            end
            CMP: begin
               if (bit_gt || bit_lt) begin
                  gt    <= bit_gt;
                  lt    <= bit_lt;
                  state <= DONE;
               end else if (cnt == '0) begin
                  eq    <= 1'b1;
                  state <= DONE;
               end else begin
                  sa  <= {sa[N-2:0], 1'b0};
                  sb  <= {sb[N-2:0], 1'b0};
                  cnt <= cnt - 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

endmodule

// File: tb/tb_comp_serial_nbit.sv
// Directed bench for comp_serial_nbit with N=4. Signed vectors are included
// when COMP_SIGNED_EN is defined.
module tb_comp_serial_nbit;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [N-1:0] a_i;
   logic [N-1:0] b_i;
   logic         sgn;
   logic         busy, done, gt, eq, lt;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   comp_serial_nbit #(.N(N)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (a_i),
      .B     (b_i),
`ifdef COMP_SIGNED_EN
      .sgn   (sgn),
`endif
      .busy  (busy),
      .done  (done),
      .gt    (gt),
      .eq    (eq),
      .lt    (lt)
   );

   typedef struct {
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic         s;
      int           k;
      logic [2:0]   res;   // {gt, eq, lt}
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Present operands, get start accepted on one edge, and return at the
   // following negedge with start low again.
   task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
      @(negedge clk);
      a_i = a; b_i = b; sgn = s; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Called at the negedge after the accept edge. It counts edges until done
   // is seen, and the count is bounded.
   task automatic wait_done(output int k);
      k = 0;
      while (done !== 1'b1 && k < 3 * N) begin
         @(posedge clk);
         k++;
         @(negedge clk);
      end
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int k;
      launch(v.a, v.b, v.s);
      check({tag, "_busy_hi"}, busy, 1);
      check({tag, "_cleared"}, {gt, eq, lt}, 0);
      wait_done(k);
      check({tag, "_k"}, k, v.k);
      check({tag, "_res"}, {gt, eq, lt}, v.res);
      @(posedge clk);
      #1;
      check({tag, "_done_1cyc"}, done, 0);
      check({tag, "_busy_lo"}, busy, 0);
      repeat (3) @(negedge clk);
      check({tag, "_hold"}, {gt, eq, lt}, v.res);
   endtask

   initial begin
      int k;
      logic seen;

      rst = 1'b1; start = 1'b0; a_i = '0; b_i = '0; sgn = 1'b0;

      vecs.push_back('{4'd9,  4'd3,  1'b0, 1, 3'b100});
      vecs.push_back('{4'd5,  4'd5,  1'b0, 4, 3'b010});
      vecs.push_back('{4'd4,  4'd5,  1'b0, 4, 3'b001});
      vecs.push_back('{4'd0,  4'd15, 1'b0, 1, 3'b001});
      vecs.push_back('{4'd6,  4'd4,  1'b0, 3, 3'b100});
      vecs.push_back('{4'd0,  4'd0,  1'b0, 4, 3'b010});
      vecs.push_back('{4'd15, 4'd15, 1'b0, 4, 3'b010});
      vecs.push_back('{4'd3,  4'd1,  1'b0, 3, 3'b100});
      vecs.push_back('{4'd10, 4'd14, 1'b0, 2, 3'b001});
`ifdef COMP_SIGNED_EN
      vecs.push_back('{4'b1000, 4'b0111, 1'b1, 1, 3'b001});
      vecs.push_back('{4'b1000, 4'b0111, 1'b0, 1, 3'b100});
      vecs.push_back('{4'd15,   4'd1,    1'b1, 1, 3'b001});
      vecs.push_back('{4'd12,   4'd14,   1'b1, 3, 3'b001});
      vecs.push_back('{4'd7,    4'd8,    1'b1, 1, 3'b100});
      vecs.push_back('{4'd5,    4'd5,    1'b1, 4, 3'b010});
`endif

      #12;
      check("reset_outputs", {busy, done, gt, eq, lt}, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("idle_after_reset", {busy, done, gt, eq, lt}, 0);

      foreach (vecs[i])
         run_vec(vecs[i], $sformatf("vec%0d", i));

      // The operands change and start stays high during CMP. All of it is ignored.
      @(negedge clk);
      a_i = 4'd5; b_i = 4'd5; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      k = 0;
      while (done !== 1'b1 && k < 3 * N) begin
         a_i = 4'(k * 3 + 1);
         b_i = ~a_i;
         @(posedge clk);
         k++;
         @(negedge clk);
      end
      check("ign_k", k, 4);
      check("ign_res", {gt, eq, lt}, 3'b010);
      // Start is still held. It is accepted in the first idle cycle.
      a_i = 4'd2; b_i = 4'd1;
      @(negedge clk);
      check("b2b_idle_gap", busy, 0);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check("b2b_accepted", busy, 1);
      check("b2b_cleared", {gt, eq, lt}, 0);
      wait_done(k);
      check("b2b_k", k, 3);
      check("b2b_res", {gt, eq, lt}, 3'b100);

      // An asynchronous reset mid-compare abandons the operation.
      run_vec('{4'd10, 4'd14, 1'b0, 2, 3'b001}, "pre_rst");
      launch(4'd5, 4'd5, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_rst_outputs", {busy, done, gt, eq, lt}, 0);
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1'b1;
      end
      check("rst_no_done", seen, 0);
      rst = 1'b0;
      run_vec('{4'd2, 4'd1, 1'b0, 3, 3'b100}, "post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
